// File: rtl/aes_buf_pkg.sv
// Shared definitions for the AES host-side word buffers (input deserialiser
// and output serialiser).
//   WORD_W      : host bus word width
//   BLK_W       : AES block width
//   buf_state_t : buffer sequencing states
package aes_buf_pkg;

    localparam int WORD_W = 32;
    localparam int BLK_W  = 128;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WAIT    = 2'd1,
        S_LOAD    = 2'd2
    } buf_state_t;

endpackage

// File: rtl/aes_input_buffer.sv
// aes_input_buffer
// Collects 32-bit host words into a 128-bit text block for the AES core.
// Word 0 lands in bits [31:0] and word 3 lands in bits [127:96]. When the
// block is complete, the buffer waits for the core to go idle and then
// issues a one-cycle load strobe.
//
// Build option: define AES_IN_KEY_EN to collect 8 words per block.
// Words 0-3 then fill key_o and words 4-7 fill text_o. Without the macro,
// key_o is tied to zero and no key registers exist.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-low
//   valid_i  in   host word valid
//   data_i   in   host word
//   ready_o  out  buffer accepts a word this cycle (0 while in reset)
//   busy_i   in   AES core busy; no load is issued while high
//   ld_o     out  one-cycle load strobe to the core
//   text_o   out  assembled text block
//   key_o    out  assembled key (0 when the key option is off)
//   ovf_o    out  sticky overrun flag, cleared only by reset
module aes_input_buffer #(
    parameter int WORD_W = 32,
    parameter int BLK_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              ready_o,
    input  logic              busy_i,
    output logic              ld_o,
    output logic [BLK_W-1:0]  text_o,
    output logic [BLK_W-1:0]  key_o,
    output logic              ovf_o
);
    import aes_buf_pkg::*;

    localparam int NW = BLK_W / WORD_W;
`ifdef AES_IN_KEY_EN
    localparam int NSLOT = 2 * NW;
    localparam int CNT_W = 3;
`else
    localparam int NSLOT = NW;
    localparam int CNT_W = 2;
`endif

    buf_state_t       state;
    buf_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             overrun;
    logic             last_slot;

    // ready_o is gated by rst so that no word is accepted during reset.
    assign ready_o   = rst && (state == S_COLLECT);
    assign accept    = valid_i && ready_o;
    assign overrun   = valid_i && !ready_o && rst;
    assign last_slot = (cnt == CNT_W'(NSLOT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_COLLECT: if (accept && last_slot) state_nxt = S_WAIT;
            S_WAIT:    if (!busy_i)             state_nxt = S_LOAD;
            S_LOAD:                             state_nxt = S_COLLECT;
            default:                            state_nxt = S_COLLECT;
        endcase
    end

    // Sequencing, slot counter and registered strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_COLLECT;
            cnt   <= '0;
            ld_o  <= 1'b0;
            ovf_o <= 1'b0;
        end else begin
            state <= state_nxt;
            // ld_o is high exactly while the FSM sits in S_LOAD.
            ld_o  <= (state_nxt == S_LOAD);
            if (accept) begin
                cnt <= last_slot ? '0 : cnt + 1'b1;
            end
            if (overrun) begin
                ovf_o <= 1'b1;
            end
        end
    end

`ifdef AES_IN_KEY_EN
    logic [BLK_W-1:0] key_q;
    assign key_o = key_q;
`else
    assign key_o = '0;
`endif

    // Slot decode and word registers; the block changes only when a word is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            text_o <= '0;
`ifdef AES_IN_KEY_EN
            key_q  <= '0;
`endif
        end else if (accept) begin
            for (int i = 0; i < NW; i++) begin
`ifdef AES_IN_KEY_EN
                if (cnt == CNT_W'(i)) begin
                    key_q[i*WORD_W +: WORD_W] <= data_i;
                end
                if (cnt == CNT_W'(i + NW)) begin
                    text_o[i*WORD_W +: WORD_W] <= data_i;
                end
`else
                if (cnt == CNT_W'(i)) begin
                    text_o[i*WORD_W +: WORD_W] <= data_i;
                end
`endif
            end
        end
    end

endmodule
